iob_native2axil: RTL
====================

// Module: iob_native2axil
// PURPOSE
//  Converts one native IOb request (valid/address/wdata/wstrb -> rdata/ready) into one AXI4-Lite transaction.
//  Sits directly downstream of a peripheral-bus split slot, so the CPU data bus can reach AXI4-Lite slaves.
//  Only one transaction is outstanding at a time; the response returns as a one-cycle ready pulse.
// PARAMETERS
//  ADDR_W   32  native/AXI address width (bytes)
//  DATA_W   32  data width; DATA_W/8 strobe bits
// PORTS
//  clk            in   1          system clock; all logic on rising edge
//  rst            in   1          asynchronous, active-low reset (0 = reset)
//  valid          in   1          native request valid; held with request until ready
//  address        in   ADDR_W     native byte address
//  wdata          in   DATA_W     native write data
//  wstrb          in   DATA_W/8   byte strobes; |wstrb=1 -> write, 0 -> read
//  rdata          out  DATA_W     read data; valid when ready=1
//  ready          out  1          one-cycle response pulse
//  err            out  1          with ready: AXI resp[1] was set (SLVERR/DECERR)
//  m_axil_aw*     out  awaddr ADDR_W, awprot 3, awvalid 1; awready in 1
//  m_axil_w*      out  wdata DATA_W, wstrb DATA_W/8, wvalid 1; wready in 1
//  m_axil_b*      in   bresp 2, bvalid 1; bready out 1
//  m_axil_ar*     out  araddr ADDR_W, arprot 3, arvalid 1; arready in 1
//  m_axil_r*      in   rdata DATA_W, rresp 2, rvalid 1; rready out 1
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ready, err, every *valid, bready, rready = 0; rdata and all addr/data regs = 0.
//  FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP. All outputs are registered.
//  IDLE: samples valid each cycle.
//   valid & |wstrb -> latch {address[ADDR_W-1:2],2'b00}, wdata, wstrb; set awvalid=wvalid=1; -> WADDR.
//   valid & ~|wstrb -> latch araddr the same way; set arvalid=1; -> RADDR.
//  WADDR: awvalid drops the cycle after an awready handshake, and wvalid the cycle after a wready handshake.
//   The two handshakes are tracked independently, in any order or together.
//   When both are done, bready=1 -> WRESP. AW and W addr/data stay stable while their valid is high.
//  WRESP: on bvalid & bready -> bready=0; err_r = bresp[1]; rdata=0 -> RESP.
//  RADDR: on arready -> arvalid=0, rready=1 -> RDATA.
//  RDATA: on rvalid & rready -> rready=0; rdata <= m_axil_rdata; err_r = rresp[1] -> RESP.
//  RESP: ready=1, err=err_r for exactly one cycle -> IDLE. rdata holds until the next response.
//  awprot=arprot=3'b000 always. Unaligned low address bits are dropped; wstrb passes through unchanged.
//  Minimum latency (slave always ready, zero-wait responses):
//   valid at cycle 0, AXI valid at cycle 1, b/r handshake at cycle 2, ready at cycle 3.
//  Request acceptance: valid is ignored outside IDLE. The master drops valid, or presents a new request,
//   in the cycle after ready; a valid seen in IDLE is always a new request. Back-to-back issue period is 4 cycles.
//  Slave stalls: wait indefinitely in any wait state; there is no timeout.
//   A bvalid/rvalid arriving outside WRESP/RDATA is not accepted (bready/rready=0).
//  Reset mid-operation: async return to IDLE and the in-flight AXI transaction is abandoned.
//   The AXI slave shares the same reset.
// TESTING
//  1 Write 0x1000_0004, wdata 0xDEADBEEF, wstrb 0xF, slave zero-wait -> awaddr/wdata/wstrb match, ready at cycle 3, err=0.
//  2 Read 0x1000_0008, slave returns 0x12345678 OKAY -> araddr 0x1000_0008, rdata=0x12345678 with ready, err=0.
//  3 Write with wready 3 cycles after awready, bvalid 2 cycles later -> wvalid held 3 cycles, single ready pulse, no duplicate AW.
//  4 Read with rresp=2'b10, then write with bresp=2'b11 -> err=1 on each ready pulse only; err=0 otherwise.
//  5 Back-to-back write then read, valid re-asserted the cycle after ready -> both transactions issued, ready pulses 4 cycles apart.
//  6 rst=0 while in WRESP with bvalid pending -> all valids/ready drop immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/iob_native2axil.sv
// iob_native2axil
//   Bridges a single native IOb request onto an AXI4-Lite master port.
//   One transaction is in flight at a time. Completion is reported on the
//   native side as a one-cycle ready pulse, with err flagging SLVERR/DECERR.
//
//   State table
//   state   | meaning
//   IDLE    | waiting for a native request
//   WADDR   | AW and W channels presented, each handshake tracked on its own
//   WRESP   | waiting for the B response
//   RADDR   | AR channel presented
//   RDATA   | waiting for the R response
//   RESP    | ready/err pulse back to the native master
//
//   Ports
//   clk, rst                 clock, async active-low reset
//   valid/address/wdata/wstrb native request (|wstrb selects write)
//   rdata/ready/err           native response
//   m_axil_*                  AXI4-Lite master (AW, W, B, AR, R channels)
module iob_native2axil #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   output logic                  err,
   output logic [ADDR_W-1:0]     m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_W-1:0]     m_axil_wdata,
   output logic [DATA_W/8-1:0]   m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_W-1:0]     m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_W-1:0]     m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                bready_q, bready_d, arvalid_q, arvalid_d;
   logic                rready_q, rready_d, ready_q, ready_d, err_q, err_d;

   // Word-aligned address; the byte offset bits are deliberately discarded.
   logic [ADDR_W-1:0]   addr_al;
   logic                unused_addr_lsb;
   assign addr_al         = {address[ADDR_W-1:2], 2'b00};
   assign unused_addr_lsb = ^address[1:0];

   always_comb begin
      state_d   = state_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (valid) begin
               if (|wstrb) begin
                  awaddr_d  = addr_al;
                  wdata_d   = wdata;
                  wstrb_d   = wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WADDR;
               end else begin
                  araddr_d  = addr_al;
                  arvalid_d = 1'b1;
                  state_d   = S_RADDR;
               end
            end
         end
         S_WADDR: begin
            // Each valid drops on its own handshake; B is opened once both are done.
            if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_WRESP;
            end
         end
         S_WRESP: begin
            if (m_axil_bvalid) begin
               bready_d = 1'b0;
               err_d    = m_axil_bresp[1];
               rdata_d  = '0;
               ready_d  = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RADDR: begin
            if (m_axil_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RDATA;
            end
         end
         S_RDATA: begin
            if (m_axil_rvalid) begin
               rready_d = 1'b0;
               rdata_d  = m_axil_rdata;
               err_d    = m_axil_rresp[1];
               ready_d  = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   assign rdata          = rdata_q;
   assign ready          = ready_q;
   assign err            = err_q;
   assign m_axil_awaddr  = awaddr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_araddr  = araddr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;

endmodule
